// File: rtl/pll_reset_seq.sv
// PLL reset / lock sequencer: pulses pll_areset, qualifies lock, then releases domain resets in order.
// Optional lock watchdog is built only when PLL_RST_SEQ_WDOG_EN is defined.
module pll_reset_seq #(
    parameter int AREST_CYCLES       = 8,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int STAGE_GAP_CYCLES   = 16,
    parameter int NUM_STAGES         = 3
`ifdef PLL_RST_SEQ_WDOG_EN
    ,
    parameter int LOCK_TIMEOUT       = 1048576
`endif
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  pll_locked,
    input  logic                  force_reset,
    output logic                  pll_areset,
    output logic [NUM_STAGES-1:0] rst_n_out,
    output logic                  ready,
    output logic [7:0]            relock_cnt,
    output logic [2:0]            dbg_state_o
);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_RUN       = 3'd4
    } state_e;

    // One shared counter serves the areset pulse, the lock qualification and the release ladder.
    localparam int REL_SPAN = NUM_STAGES * STAGE_GAP_CYCLES;
    localparam int CNT_MAX0 = (AREST_CYCLES > LOCK_STABLE_CYCLES) ? AREST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX  = (CNT_MAX0 > REL_SPAN) ? CNT_MAX0 : REL_SPAN;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
    logic                    areset_q, areset_d;
    logic [NUM_STAGES-1:0]   rst_q, rst_d;
    logic                    ready_q, ready_d;
    logic [7:0]              relock_q, relock_d;
    logic                    meta_q, lock_s_q;
    logic                    lock_loss;
    logic                    timeout;

`ifdef PLL_RST_SEQ_WDOG_EN
    localparam int WDOG_W = $clog2(LOCK_TIMEOUT + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              in_lock_wait;

    assign in_lock_wait = (state_q == S_WAIT_LOCK) || (state_q == S_STABLE);
    assign wdog_d       = in_lock_wait ? (wdog_q + WDOG_W'(1)) : '0;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) wdog_q <= '0;
        else            wdog_q <= wdog_d;
    end
`endif

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            meta_q   <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            meta_q   <= pll_locked;
            lock_s_q <= meta_q;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q  <= S_PLL_RST;
            cnt_q    <= '0;
            areset_q <= 1'b1;
            rst_q    <= '0;
            ready_q  <= 1'b0;
            relock_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            areset_q <= areset_d;
            rst_q    <= rst_d;
            ready_q  <= ready_d;
            relock_q <= relock_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        areset_d  = areset_q;
        rst_d     = rst_q;
        ready_d   = ready_q;
        relock_d  = relock_q;
        lock_loss = 1'b0;
        timeout   = 1'b0;

        case (state_q)
            S_PLL_RST: begin
                areset_d = 1'b1;
                cnt_d    = cnt_inc;
                if (cnt_q == CNT_W'(AREST_CYCLES - 1)) begin
                    state_d  = S_WAIT_LOCK;
                    cnt_d    = '0;
                    areset_d = 1'b0;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end
            end
            S_STABLE: begin
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_W'(LOCK_STABLE_CYCLES)) begin
                    state_d  = S_RELEASE;
                    cnt_d    = '0;
                    rst_d[0] = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RELEASE: begin
                if (!lock_s_q) begin
                    lock_loss = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                    for (int k = 1; k < NUM_STAGES; k++) begin
                        if (cnt_inc == CNT_W'(k * STAGE_GAP_CYCLES)) rst_d[k] = 1'b1;
                    end
                    if (cnt_inc == CNT_W'(REL_SPAN)) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
                        ready_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (!lock_s_q) lock_loss = 1'b1;
            end
            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
            end
        endcase

`ifdef PLL_RST_SEQ_WDOG_EN
        if (in_lock_wait && (state_d != S_RELEASE) && (wdog_q == WDOG_W'(LOCK_TIMEOUT - 1)))
            timeout = 1'b1;
`endif

        if (force_reset || lock_loss || timeout) begin
            state_d  = S_PLL_RST;
            cnt_d    = '0;
            areset_d = 1'b1;
            rst_d    = '0;
            ready_d  = 1'b0;
        end
        // A forced restart is not a lock-loss event, even when both coincide.
        if (lock_loss && !force_reset && (relock_q != 8'hFF))
            relock_d = relock_q + 8'd1;
    end

    assign pll_areset  = areset_q;
    assign rst_n_out   = rst_q;
    assign ready       = ready_q;
    assign relock_cnt  = relock_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: expected output-change events (value + cycle) are queued by the drivers
// and matched by a monitor whenever the {areset, rst_n_out, ready, relock_cnt} tuple changes.
module tb_pll_reset_seq;

    localparam int AREST   = 4;
    localparam int STABLE  = 8;
    localparam int GAP     = 2;
    localparam int STAGES  = 3;
    localparam int TIMEOUT = 32;

    logic              sys_clk;
    logic              sys_rst_n;
    logic              pll_locked;
    logic              force_reset;
    logic              pll_areset;
    logic [STAGES-1:0] rst_n_out;
    logic              ready;
    logic [7:0]        relock_cnt;
    logic [2:0]        dbg_state;

    pll_reset_seq #(
        .AREST_CYCLES       (AREST),
        .LOCK_STABLE_CYCLES (STABLE),
        .STAGE_GAP_CYCLES   (GAP),
        .NUM_STAGES         (STAGES)
`ifdef PLL_RST_SEQ_WDOG_EN
        ,
        .LOCK_TIMEOUT       (TIMEOUT)
`endif
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .pll_locked  (pll_locked),
        .force_reset (force_reset),
        .pll_areset  (pll_areset),
        .rst_n_out   (rst_n_out),
        .ready       (ready),
        .relock_cnt  (relock_cnt),
        .dbg_state_o (dbg_state)
    );

    // clock / cycle counter
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // scoreboard: {areset, rst_n_out, ready, relock_cnt, cycle[19:0]}
    logic [32:0] exp_q[$];
    logic [12:0] prev_snap;
    logic        mon_en = 1'b0;

    function automatic logic [12:0] mk(input logic a, input logic [2:0] r, input logic rd, input logic [7:0] rc);
        return {a, r, rd, rc};
    endfunction

    task automatic push_evt(input logic [12:0] val, input int at_cyc);
        exp_q.push_back({val, 20'(at_cyc)});
    endtask

    task automatic push_release(input int base, input logic [7:0] rc);
        logic [2:0] rv;
        rv = 3'b000;
        for (int k = 0; k < STAGES; k++) begin
            rv[k] = 1'b1;
            push_evt(mk(1'b0, rv, 1'b0, rc), base + k * GAP);
        end
        push_evt(mk(1'b0, 3'b111, 1'b1, rc), base + STAGES * GAP);
    endtask

    always @(negedge sys_clk) begin
        logic [12:0] snap;
        logic [32:0] e;
        if (mon_en) begin
            snap = {pll_areset, rst_n_out, ready, relock_cnt};
            if (snap != prev_snap) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_evt", 64'({snap, 20'(cyc)}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("evt", 64'({snap, 20'(cyc)}), 64'(e));
                end
                prev_snap = snap;
            end
        end
    end

    // driver tasks
    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check_drained(input string tag);
        check_val(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic do_reset(input logic lock_val, output int c0);
        mon_en = 1'b0;
        @(negedge sys_clk);
        sys_rst_n   = 1'b0;
        pll_locked  = lock_val;
        force_reset = 1'b0;
        wait_cyc(2);
        check_val("rst_areset", 64'(pll_areset), 64'd1);
        check_val("rst_rst_n",  64'(rst_n_out),  64'd0);
        check_val("rst_ready",  64'(ready),      64'd0);
        check_val("rst_relock", 64'(relock_cnt), 64'd0);
        check_val("rst_state",  64'(dbg_state),  64'd0);
        prev_snap = mk(1'b1, 3'b000, 1'b0, 8'd0);
        sys_rst_n = 1'b1;
        c0 = cyc;
        mon_en = 1'b1;
    endtask

    initial begin
        int c0, d, e, f, g, h, k, n;
        logic [7:0] exp_rc;

        sys_rst_n   = 1'b0;
        pll_locked  = 1'b0;
        force_reset = 1'b0;

        // 1: lock present from the start
        do_reset(1'b1, c0);
        push_evt(mk(1'b0, 3'b000, 1'b0, 8'd0), c0 + AREST);
        push_release(c0 + AREST + 1 + STABLE, 8'd0);
        wait_cyc(AREST + 1 + STABLE + STAGES * GAP + 4);
        check_drained("s1_drain");

        // 2: one-cycle lock glitch at cnt=5 restarts qualification
        do_reset(1'b0, c0);
        push_evt(mk(1'b0, 3'b000, 1'b0, 8'd0), c0 + AREST);
        wait_cyc(6);
        pll_locked = 1'b1;
        wait_cyc(6);
        d = cyc;
        pll_locked = 1'b0;
        wait_cyc(1);
        pll_locked = 1'b1;
        push_release(d + 4 + STABLE, 8'd0);
        wait_cyc(4 + STABLE + STAGES * GAP + 2);
        check_drained("s2_drain");

        // 3: lock loss in run
        e = cyc;
        pll_locked = 1'b0;
        push_evt(mk(1'b1, 3'b000, 1'b0, 8'd1), e + 3);
        push_evt(mk(1'b0, 3'b000, 1'b0, 8'd1), e + 3 + AREST);
        wait_cyc(10);
        f = cyc;
        pll_locked = 1'b1;
        push_release(f + 3 + STABLE, 8'd1);
        wait_cyc(3 + STABLE + STAGES * GAP + 2);
        check_drained("s3_drain");

        // 4a: force_reset coincident with lock loss -> no increment
        g = cyc;
        pll_locked = 1'b0;
        push_evt(mk(1'b1, 3'b000, 1'b0, 8'd1), g + 3);
        push_evt(mk(1'b0, 3'b000, 1'b0, 8'd1), g + 3 + AREST);
        wait_cyc(2);
        force_reset = 1'b1;
        wait_cyc(1);
        force_reset = 1'b0;
        wait_cyc(7);
        h = cyc;
        pll_locked = 1'b1;
        push_release(h + 3 + STABLE, 8'd1);
        wait_cyc(20);
        check_drained("s4a_drain");

        // 4b: force_reset alone while locked
        k = cyc;
        push_evt(mk(1'b1, 3'b000, 1'b0, 8'd1), k + 1);
        push_evt(mk(1'b0, 3'b000, 1'b0, 8'd1), k + 1 + AREST);
        push_release(k + 1 + AREST + 1 + STABLE, 8'd1);
        force_reset = 1'b1;
        wait_cyc(1);
        force_reset = 1'b0;
        wait_cyc(24);
        check_drained("s4b_drain");

        // 4c: 256 more lock losses saturate relock_cnt
        mon_en = 1'b0;
        exp_rc = 8'd1;
        for (int i = 0; i < 256; i++) begin
            n = 0;
            while (rst_n_out[0] !== 1'b1 && n < 40) begin
                @(negedge sys_clk);
                n++;
            end
            check_val("wait_release", 64'(rst_n_out[0]), 64'd1);
            pll_locked = 1'b0;
            wait_cyc(4);
            pll_locked = 1'b1;
            if (exp_rc != 8'hFF) exp_rc = exp_rc + 8'd1;
        end
        check_val("relock_sat", 64'(relock_cnt), 64'(exp_rc));
        check_val("relock_areset", 64'(pll_areset), 64'd1);

        // 5: no lock at all
        do_reset(1'b0, c0);
        push_evt(mk(1'b0, 3'b000, 1'b0, 8'd0), c0 + AREST);
`ifdef PLL_RST_SEQ_WDOG_EN
        for (int i = 0; i < 2; i++) begin
            push_evt(mk(1'b1, 3'b000, 1'b0, 8'd0), c0 + (i + 1) * TIMEOUT + (i + 1) * AREST);
            push_evt(mk(1'b0, 3'b000, 1'b0, 8'd0), c0 + (i + 1) * (AREST + TIMEOUT) + AREST);
        end
`endif
        wait_cyc(2 * (AREST + TIMEOUT) + AREST + 2);
        check_drained("s5_drain");
        check_val("s5_areset", 64'(pll_areset), 64'd0);
        check_val("s5_state",  64'(dbg_state),  64'd1);

        // 6: async reset in the middle of the release ladder
        do_reset(1'b1, c0);
        push_evt(mk(1'b0, 3'b000, 1'b0, 8'd0), c0 + AREST);
        push_evt(mk(1'b0, 3'b001, 1'b0, 8'd0), c0 + AREST + 1 + STABLE);
        push_evt(mk(1'b0, 3'b011, 1'b0, 8'd0), c0 + AREST + 1 + STABLE + GAP);
        wait_cyc(AREST + 1 + STABLE + GAP + 1);
        check_drained("s6_drain");
        mon_en = 1'b0;
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_val("async_areset", 64'(pll_areset), 64'd1);
        check_val("async_rst_n",  64'(rst_n_out),  64'd0);
        check_val("async_ready",  64'(ready),      64'd0);
        check_val("async_relock", 64'(relock_cnt), 64'd0);
        check_val("async_state",  64'(dbg_state),  64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
